wb2av: RTL and testbench
========================

WB2AV -- requirements
Module: wb2av

Interface
- REQ-001 The block SHALL have these parameters:
  - AW, 30, Wishbone word-address width.
  - TIMEOUT_CYCLES, 255, Avalon wait limit in cycles (timeout build only).
- REQ-002 The block SHALL have these ports; clock is clk; reset is rst, asynchronous, active-high:
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
  - wb_adr  in  AW  word address
  - wb_dat_w  in  32  write data
  - wb_dat_r  out  32  read data
  - wb_sel  in  4  byte selects
  - wb_stall  out  1  pipelined stall
  - wb_cyc  in  1  cycle
  - wb_stb  in  1  strobe
  - wb_ack  out  1  acknowledge
  - wb_we  in  1  write enable
  - wb_err  out  1  error
  - av_address  out  AW+2  byte address
  - av_readdata  in  32  read data
  - av_writedata  out  32  write data
  - av_byteenable  out  4  byte enables
  - av_write  out  1  write request
  - av_read  out  1  read request
  - av_waitrequest  in  1  slave not ready
  - av_readdatavalid  in  1  read data valid

Function
- REQ-003 The block SHALL be a pipelined-Wishbone slave to Avalon-MM master bridge with at most one transaction outstanding.
- REQ-004 FSM states SHALL be IDLE, CMD, RD_WAIT and RESP.
- REQ-005 wb_stall SHALL be 0 in IDLE and 1 in every other state.
- REQ-006 In IDLE, wb_cyc&wb_stb SHALL register the request: address {wb_adr,2'b00}, wb_dat_w, wb_sel and wb_we. The FSM then moves to CMD.
- REQ-007 In CMD, av_write (wb_we=1) or av_read (wb_we=0) SHALL be held, together with stable address, data and byteenable, until a cycle with av_waitrequest=0.
- REQ-008 On write acceptance the FSM SHALL go to RESP. On read acceptance it SHALL go to RD_WAIT and drop av_read the next cycle.
- REQ-009 In RD_WAIT, av_readdatavalid=1 SHALL latch av_readdata into wb_dat_r and move the FSM to RESP.
- REQ-010 RESP SHALL pulse wb_ack for exactly one cycle, then return to IDLE.
- REQ-011 Zero-wait latency SHALL be:
  - write: stb cycle 0, av_write cycle 1, ack cycle 2.
  - read with readdatavalid at cycle 2: ack cycle 3.
- REQ-012 If wb_cyc drops mid-transaction, the Avalon transaction SHALL still complete, but wb_ack and wb_err SHALL be suppressed.
- REQ-013 wb_dat_r SHALL hold its last read value until the next read completes.
- REQ-014 av_readdatavalid outside RD_WAIT SHALL be ignored.

Reset
- REQ-015 While rst=1, state SHALL be IDLE and every output SHALL be 0 (wb_stall, wb_ack, wb_err, wb_dat_r and all av_* outputs).
- REQ-016 Reset asserted mid-transaction SHALL drop av_read/av_write immediately and return to IDLE with no ack.

Configuration
- REQ-017 With WB2AV_TIMEOUT_EN defined, a counter SHALL run in CMD and RD_WAIT and clear on each state entry. On reaching TIMEOUT_CYCLES it SHALL:
  - drop av_read/av_write,
  - pulse wb_err for one cycle instead of wb_ack,
  - return to IDLE.
- REQ-018 Without WB2AV_TIMEOUT_EN, the bridge SHALL wait indefinitely, and wb_err SHALL be tied 0.

Structure
- REQ-019 Package wb2av_pkg SHALL hold the FSM state enum and the TIMEOUT_CYCLES default constant.
- REQ-020 The timeout counter SHALL be sub-module wb2av_timeout, instantiated only under WB2AV_TIMEOUT_EN.

Verification
- REQ-021 Write, wb_adr=0x100, dat=0xDEADBEEF, sel=0xF, no waitrequest:
  - av_address=0x400 and av_write at cycle 1,
  - wb_ack at cycle 2.
- REQ-022 Read with waitrequest held 3 cycles and readdatavalid 2 cycles after acceptance, av_readdata=0x12345678:
  - av_read high 4 cycles,
  - wb_dat_r=0x12345678 with a single ack.
- REQ-023 Back-to-back stb, write then read: the second request SHALL stall until the first acks, and both SHALL complete in order.
- REQ-024 wb_cyc dropped during RD_WAIT: no ack, Avalon read completes, and the next request is served normally.
- REQ-025 WB2AV_TIMEOUT_EN with TIMEOUT_CYCLES=8 and waitrequest stuck 1: wb_err pulses once after 8 CMD cycles and av_read=0. Without the macro, no err.
- REQ-026 rst pulsed while av_write and waitrequest are high: all outputs are 0 the same cycle, and there is no ack afterwards.

Source files
------------

// File: rtl/wb2av_pkg.sv
// wb2av shared types: FSM state encoding and default Avalon wait limit.
package wb2av_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RD_WAIT,
        RESP
    } state_t;

    localparam int unsigned WB2AV_TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb2av_timeout.sv
// wb2av wait-limit counter; present only when WB2AV_TIMEOUT_EN is defined.
import wb2av_pkg::*;

module wb2av_timeout #(
    parameter int unsigned LIMIT = WB2AV_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    // Counts cycles already spent in the current waiting state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || !i_run) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_run && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/wb2av.sv
// Pipelined Wishbone slave to Avalon-MM master bridge, one transaction in flight.
// Define WB2AV_TIMEOUT_EN to abort stuck Avalon transfers with wb_err.
import wb2av_pkg::*;

module wb2av #(
    parameter int          AW             = 30,
    parameter int unsigned TIMEOUT_CYCLES = WB2AV_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wb_adr,
    input  logic [31:0]   wb_dat_w,
    output logic [31:0]   wb_dat_r,
    input  logic [3:0]    wb_sel,
    output logic          wb_stall,
    input  logic          wb_cyc,
    input  logic          wb_stb,
    output logic          wb_ack,
    input  logic          wb_we,
    output logic          wb_err,
    output logic [AW+1:0] av_address,
    input  logic [31:0]   av_readdata,
    output logic [31:0]   av_writedata,
    output logic [3:0]    av_byteenable,
    output logic          av_write,
    output logic          av_read,
    input  logic          av_waitrequest,
    input  logic          av_readdatavalid
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("wb2av: TIMEOUT_CYCLES must be nonzero");
    end

    state_t        r_state;
    logic          r_live;
    logic          r_stall;
    logic          r_ack;
    logic          r_err;
    logic          r_write;
    logic          r_read;
    logic [AW+1:0] r_address;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_dat_r;
    logic          w_live;
    logic          w_expired;

    assign w_live = r_live && wb_cyc;

`ifdef WB2AV_TIMEOUT_EN
    logic w_run;
    logic w_clr;

    assign w_run = (r_state == CMD) || (r_state == RD_WAIT);
    assign w_clr = (r_state == CMD) && !av_waitrequest;

    wb2av_timeout #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_run),
        .i_clr     (w_clr),
        .o_expired (w_expired)
    );

    assign wb_err = r_err;
`else
    assign w_expired = 1'b0;
    assign wb_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_live    <= 1'b0;
            r_stall   <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_write   <= 1'b0;
            r_read    <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_dat_r   <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            // An abandoned cycle still finishes on Avalon but is never answered.
            if (r_state != IDLE && !wb_cyc) begin
                r_live <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (wb_cyc && wb_stb) begin
                        r_address <= {wb_adr, 2'b00};
                        r_wdata   <= wb_dat_w;
                        r_be      <= wb_sel;
                        r_write   <= wb_we;
                        r_read    <= !wb_we;
                        r_live    <= 1'b1;
                        r_stall   <= 1'b1;
                        r_state   <= CMD;
                    end
                end
                CMD: begin
                    if (!av_waitrequest) begin
                        r_write <= 1'b0;
                        r_read  <= 1'b0;
                        if (r_write) begin
                            r_ack   <= w_live;
                            r_state <= RESP;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end else if (w_expired) begin
                        r_write <= 1'b0;
                        r_read  <= 1'b0;
                        r_err   <= w_live;
                        r_state <= RESP;
                    end
                end
                RD_WAIT: begin
                    if (av_readdatavalid) begin
                        r_dat_r <= av_readdata;
                        r_ack   <= w_live;
                        r_state <= RESP;
                    end else if (w_expired) begin
                        r_err   <= w_live;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_stall <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_stall      = r_stall;
    assign wb_ack        = r_ack;
    assign wb_dat_r      = r_dat_r;
    assign av_address    = r_address;
    assign av_writedata  = r_wdata;
    assign av_byteenable = r_be;
    assign av_write      = r_write;
    assign av_read       = r_read;

endmodule

// File: tb/tb_wb2av.sv
// Self-checking bench for wb2av: directed and randomized Wishbone/Avalon transfers.
// Define WB2AV_TIMEOUT_EN on both bench and RTL to exercise the timeout build.
module tb_wb2av;

    typedef struct {
        bit          we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          nw;
        int          d;
        logic [31:0] rd;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_stall;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;
    logic        wb_we;
    logic        wb_err;
    logic [31:0] av_address;
    logic [31:0] av_readdata;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_write;
    logic        av_read;
    logic        av_waitrequest;
    logic        av_readdatavalid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd = 32'h0;

    always #5 clk = ~clk;

    wb2av #(
        .AW               (30),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wb_adr           (wb_adr),
        .wb_dat_w         (wb_dat_w),
        .wb_dat_r         (wb_dat_r),
        .wb_sel           (wb_sel),
        .wb_stall         (wb_stall),
        .wb_cyc           (wb_cyc),
        .wb_stb           (wb_stb),
        .wb_ack           (wb_ack),
        .wb_we            (wb_we),
        .wb_err           (wb_err),
        .av_address       (av_address),
        .av_readdata      (av_readdata),
        .av_writedata     (av_writedata),
        .av_byteenable    (av_byteenable),
        .av_write         (av_write),
        .av_read          (av_read),
        .av_waitrequest   (av_waitrequest),
        .av_readdatavalid (av_readdatavalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we  = 1'($urandom_range(0, 1));
        t.adr = 30'($urandom);
        t.dat = $urandom;
        t.sel = 4'($urandom);
        t.nw  = $urandom_range(0, 3);
        t.d   = $urandom_range(1, 3);
        t.rd  = $urandom;
        return t;
    endfunction

    // One transfer: cycle 0 presents the strobe, the Avalon slave accepts at
    // cycle a = 1+nw, read data arrives d cycles later, ack one cycle after.
    task automatic do_txn(input txn_t t, input bit drop, input bit chain,
                          input txn_t n);
        int          a;
        int          done;
        int          dropc;
        logic [31:0] prev;
        logic [31:0] exp_d;
        logic [31:0] exp_a;
        bit          exp_w;
        bit          exp_r;
        bit          exp_k;
        bit          exp_s;
        a     = 1 + t.nw;
        done  = t.we ? a + 1 : a + t.d + 1;
        dropc = t.we ? a : a + 1;
        prev  = model_rd;
        exp_a = 32'(t.adr) * 4;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we = t.we;
        wb_adr = t.adr;
        wb_dat_w = t.dat;
        wb_sel = t.sel;
        av_waitrequest = 1'($urandom_range(0, 1));
        av_readdatavalid = 1'($urandom_range(0, 1));
        av_readdata = $urandom;
        checks++;
        if (wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle got %b exp 0", wb_stall);
        end
        tick();
        for (int c = 1; c <= done + 1; c++) begin
            if (chain) begin
                wb_stb = 1'b1;
                wb_we = n.we;
                wb_adr = n.adr;
                wb_dat_w = n.dat;
                wb_sel = n.sel;
            end else begin
                wb_stb = 1'b0;
                wb_adr = 30'($urandom);
                wb_dat_w = $urandom;
            end
            wb_cyc = (drop && c >= dropc) ? 1'b0 : 1'b1;
            av_waitrequest = (c < a) ? 1'b1 :
                             (c == a) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!t.we && c == a + t.d) begin
                av_readdatavalid = 1'b1;
                av_readdata = t.rd;
            end else begin
                av_readdatavalid = (c <= a) ? 1'($urandom_range(0, 1)) : 1'b0;
                av_readdata = $urandom;
            end
            exp_w = t.we && c <= a;
            exp_r = !t.we && c <= a;
            exp_k = (c == done) && !drop;
            exp_s = (c <= done);
            exp_d = (!t.we && c >= done) ? t.rd : prev;
            checks++;
            if (av_write !== exp_w) begin
                errors++;
                $display("FAIL av_write c=%0d got %b exp %b", c, av_write, exp_w);
            end
            checks++;
            if (av_read !== exp_r) begin
                errors++;
                $display("FAIL av_read c=%0d got %b exp %b", c, av_read, exp_r);
            end
            if (c <= a) begin
                checks++;
                if (av_address !== exp_a || av_byteenable !== t.sel) begin
                    errors++;
                    $display("FAIL av_addr c=%0d got %h/%h exp %h/%h",
                             c, av_address, av_byteenable, exp_a, t.sel);
                end
                if (t.we) begin
                    checks++;
                    if (av_writedata !== t.dat) begin
                        errors++;
                        $display("FAIL av_wdata c=%0d got %h exp %h",
                                 c, av_writedata, t.dat);
                    end
                end
            end
            checks++;
            if (wb_ack !== exp_k) begin
                errors++;
                $display("FAIL wb_ack c=%0d got %b exp %b", c, wb_ack, exp_k);
            end
            checks++;
            if (wb_err !== 1'b0) begin
                errors++;
                $display("FAIL wb_err c=%0d got %b exp 0", c, wb_err);
            end
            checks++;
            if (wb_stall !== exp_s) begin
                errors++;
                $display("FAIL wb_stall c=%0d got %b exp %b", c, wb_stall, exp_s);
            end
            checks++;
            if (wb_dat_r !== exp_d) begin
                errors++;
                $display("FAIL wb_dat_r c=%0d got %h exp %h", c, wb_dat_r, exp_d);
            end
            if (c <= done) tick();
        end
        if (!t.we) model_rd = t.rd;
    endtask

    // Quiet bus with readdatavalid noise that the bridge must ignore.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            wb_stb = 1'b0;
            wb_cyc = 1'($urandom_range(0, 1));
            av_waitrequest = 1'($urandom_range(0, 1));
            av_readdatavalid = 1'($urandom_range(0, 1));
            av_readdata = $urandom;
            tick();
            checks++;
            if ({wb_ack, wb_stall, av_read, av_write} !== 4'b0 ||
                wb_dat_r !== model_rd) begin
                errors++;
                $display("FAIL idle got %b%b%b%b/%h exp 0000/%h", wb_ack,
                         wb_stall, av_read, av_write, wb_dat_r, model_rd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we = 1'b0;
        wb_adr = '0;
        wb_dat_w = '0;
        wb_sel = '0;
        av_readdata = '0;
        av_waitrequest = 1'b0;
        av_readdatavalid = 1'b0;
        tick();
        tick();
        checks++;
        if ({wb_dat_r, wb_stall, wb_ack, wb_err, av_address, av_writedata,
             av_byteenable, av_write, av_read} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero exp all 0");
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        txn_t t;
        txn_t z;
        z = rand_txn();
        t.we = 1'b1; t.adr = 30'h100; t.dat = 32'hDEADBEEF; t.sel = 4'hF;
        t.nw = 0; t.d = 1; t.rd = 32'h0;
        do_txn(t, 1'b0, 1'b0, z);
        checks++;
        if (av_writedata !== 32'hDEADBEEF || av_address !== 32'h400) begin
            errors++;
            $display("FAIL wr_hold got %h/%h exp 00000400/deadbeef",
                     av_address, av_writedata);
        end
        idle_cycles(2);
        t.we = 1'b0; t.adr = 30'h2A5; t.sel = 4'h3;
        t.nw = 3; t.d = 2; t.rd = 32'h12345678;
        do_txn(t, 1'b0, 1'b0, z);
        idle_cycles(1);
        t.nw = 0; t.d = 1; t.rd = 32'hA5A5_0F0F;
        do_txn(t, 1'b0, 1'b0, z);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        txn_t w;
        txn_t r;
        w = rand_txn();
        r = rand_txn();
        w.we = 1'b1;
        r.we = 1'b0;
        do_txn(w, 1'b0, 1'b1, r);
        do_txn(r, 1'b0, 1'b0, w);
        idle_cycles(1);
    endtask

    task automatic test_cyc_drop();
        txn_t r;
        r = rand_txn();
        r.we = 1'b0;
        r.d = 3;
        do_txn(r, 1'b1, 1'b0, r);
        idle_cycles(1);
        r = rand_txn();
        do_txn(r, 1'b0, 1'b0, r);
        idle_cycles(1);
    endtask

    task automatic test_timeout();
`ifdef WB2AV_TIMEOUT_EN
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we = 1'b0;
        wb_adr = 30'($urandom);
        av_waitrequest = 1'b1;
        av_readdatavalid = 1'b0;
        tick();
        wb_stb = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (av_read !== (c <= 8) || wb_err !== (c == 9) || wb_ack !== 1'b0 ||
                wb_stall !== (c <= 9)) begin
                errors++;
                $display("FAIL timeout c=%0d got rd%b err%b ack%b st%b", c,
                         av_read, wb_err, wb_ack, wb_stall);
            end
            tick();
        end
        av_waitrequest = 1'b0;
        idle_cycles(1);
`else
        txn_t r;
        r = rand_txn();
        r.we = 1'b0;
        r.nw = 20;
        do_txn(r, 1'b0, 1'b0, r);
        idle_cycles(1);
`endif
    endtask

    task automatic test_mid_reset();
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we = 1'b1;
        wb_adr = 30'h55;
        wb_dat_w = 32'hCAFEF00D;
        wb_sel = 4'hF;
        av_waitrequest = 1'b1;
        tick();
        wb_stb = 1'b0;
        tick();
        checks++;
        if (av_write !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_write got %b exp 1", av_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({wb_dat_r, wb_stall, wb_ack, wb_err, av_address, av_writedata,
             av_byteenable, av_write, av_read} !== '0) begin
            errors++;
            $display("FAIL async_reset got w%b s%b a%b exp all 0",
                     av_write, wb_stall, wb_ack);
        end
        model_rd = 32'h0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({wb_ack, wb_err, wb_stall, av_write} !== 4'b0) begin
                errors++;
                $display("FAIL post_reset got %b%b%b%b exp 0000",
                         wb_ack, wb_err, wb_stall, av_write);
            end
        end
    endtask

    task automatic test_random();
        txn_t cur;
        txn_t nxt;
        bit   chain;
        bit   drop;
        cur = rand_txn();
        for (int i = 0; i < 40; i++) begin
            nxt = rand_txn();
            chain = ($urandom_range(0, 2) == 0);
            drop = !chain && ($urandom_range(0, 7) == 0);
            do_txn(cur, drop, chain, nxt);
            if (!chain) idle_cycles($urandom_range(0, 2));
            cur = nxt;
        end
        do_txn(cur, 1'b0, 1'b0, cur);
        idle_cycles(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_cyc_drop();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
